// File: rtl/pc_update_sequencer.sv
// Multi-cycle PC sequencer: steps FETCH..WB and issues a one-cycle PC write at WB.
// Optional bounds check on the selected target is enabled by defining PC_BOUNDS_CHECK_EN.
module pc_update_sequencer #(
   parameter int                ADDR_W   = 10,
   parameter logic [ADDR_W-1:0] TRAP_VEC = 10'h3F0,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [ADDR_W-1:0] PC_LIMIT = 10'h3EF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              halt,
   input  logic              stall,
   input  logic              branch_req,
   input  logic [ADDR_W-1:0] branch_tgt,
   input  logic              jump_req,
   input  logic [ADDR_W-1:0] jump_tgt,
   input  logic              trap_req,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] new_pc,
   output logic              pc_we,
   output logic [2:0]        phase,
   output logic              busy,
   output logic              fault
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5
   } phase_t;

   phase_t            state, state_nxt;
   logic [ADDR_W-1:0] pc_q, jump_tgt_q, branch_tgt_q;
   logic [ADDR_W-1:0] sel_pc, next_pc;
   logic              jump_pend, branch_pend, trap_pend;
   logic              trap_now, commit, out_of_bounds;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      commit    = 1'b0;
      case (state)
         IDLE:   if (start)  state_nxt = FETCH;
         FETCH:  if (!stall) state_nxt = DECODE;
         DECODE: if (!stall) state_nxt = EXEC;
         EXEC:   if (!stall) state_nxt = MEM;
         MEM:    if (!stall) state_nxt = WB;
         WB: begin
            if (!stall) begin
               commit    = 1'b1;
               state_nxt = halt ? IDLE : FETCH;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A trap raised during the commit cycle itself still wins, so it is never lost.
   always_comb begin
      trap_now = trap_pend | trap_req;
      if (jump_pend)        sel_pc = jump_tgt_q;
      else if (branch_pend) sel_pc = branch_tgt_q;
      else                  sel_pc = pc_q + ADDR_W'(1);
   end

`ifdef PC_BOUNDS_CHECK_EN
   assign out_of_bounds = (sel_pc > PC_LIMIT);
`else
   logic unused_pc_limit;
   assign unused_pc_limit = ^PC_LIMIT;
   assign out_of_bounds   = 1'b0;
`endif

   assign next_pc = (trap_now || out_of_bounds) ? TRAP_VEC : sel_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         trap_pend    <= 1'b0;
         jump_pend    <= 1'b0;
         branch_pend  <= 1'b0;
         jump_tgt_q   <= '0;
         branch_tgt_q <= '0;
      end else if (commit) begin
         pc_q        <= next_pc;
         trap_pend   <= 1'b0;
         jump_pend   <= 1'b0;
         branch_pend <= 1'b0;
      end else begin
         if (state != IDLE && trap_req) trap_pend <= 1'b1;
         if (state == EXEC && !stall) begin
            jump_pend    <= jump_req;
            jump_tgt_q   <= jump_tgt;
            branch_pend  <= branch_req;
            branch_tgt_q <= branch_tgt;
         end
      end
   end

   assign pc     = pc_q;
   assign new_pc = (state == WB) ? next_pc : pc_q;
   assign pc_we  = commit;
   assign phase  = state;
   assign busy   = (state != IDLE);
   assign fault  = commit && !trap_now && out_of_bounds;

endmodule

// File: tb/tb_pc_update_sequencer.sv
// Directed testbench for pc_update_sequencer (default build, bounds check disabled).
module tb_pc_update_sequencer;

   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst_n, start, halt, stall;
   logic              branch_req, jump_req, trap_req;
   logic [ADDR_W-1:0] branch_tgt, jump_tgt;
   logic [ADDR_W-1:0] pc, new_pc;
   logic              pc_we, busy, fault;
   logic [2:0]        phase;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   pc_update_sequencer #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .stall(stall),
      .branch_req(branch_req), .branch_tgt(branch_tgt),
      .jump_req(jump_req), .jump_tgt(jump_tgt), .trap_req(trap_req),
      .pc(pc), .new_pc(new_pc), .pc_we(pc_we), .phase(phase),
      .busy(busy), .fault(fault)
   );

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Walks one plain instruction starting in FETCH and ends in the next FETCH.
   task automatic run_instr(input string tag, input logic [9:0] exp_pc,
                            input logic [9:0] exp_new);
      check_output({tag, "_fetch"}, phase, 3'd1);
      check_output({tag, "_pc"}, pc, exp_pc);
      check_output({tag, "_busy"}, busy, 1'b1);
      tick(); tick(); tick();
      check_output({tag, "_mem_we"}, pc_we, 1'b0);
      tick();
      check_output({tag, "_wb"}, phase, 3'd5);
      check_output({tag, "_we"}, pc_we, 1'b1);
      check_output({tag, "_newpc"}, new_pc, exp_new);
      check_output({tag, "_fault"}, fault, 1'b0);
      tick();
      check_output({tag, "_commit_pc"}, pc, exp_new);
      check_output({tag, "_we_drop"}, pc_we, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; halt = 1'b0; stall = 1'b0;
      branch_req = 1'b0; jump_req = 1'b0; trap_req = 1'b0;
      branch_tgt = '0; jump_tgt = '0;
      #12;
      check_output("rst_phase", phase, 3'd0);
      check_output("rst_pc", pc, 10'h000);
      check_output("rst_newpc", new_pc, 10'h000);
      check_output("rst_we", pc_we, 1'b0);
      check_output("rst_busy", busy, 1'b0);
      check_output("rst_fault", fault, 1'b0);

      rst_n = 1'b1;
      tick();
      check_output("idle_hold", phase, 3'd0);
      start = 1'b1;
      tick();
      start = 1'b0;

      run_instr("seq0", 10'h000, 10'h001);
      run_instr("seq1", 10'h001, 10'h002);
      run_instr("seq2", 10'h002, 10'h003);

      // Jump and branch together in EXEC; start while busy must be ignored.
      tick(); tick();
      branch_req = 1'b1; branch_tgt = 10'h040;
      jump_req   = 1'b1; jump_tgt   = 10'h100;
      tick();
      branch_req = 1'b0; jump_req = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check_output("jmp_we", pc_we, 1'b1);
      check_output("jmp_newpc", new_pc, 10'h100);
      tick();
      check_output("jmp_pc", pc, 10'h100);
      run_instr("post_jmp", 10'h100, 10'h101);

      // Trap raised in DECODE beats a branch latched in EXEC.
      tick();
      trap_req = 1'b1;
      tick();
      trap_req = 1'b0; branch_req = 1'b1; branch_tgt = 10'h040;
      tick();
      branch_req = 1'b0;
      tick();
      check_output("trap_we", pc_we, 1'b1);
      check_output("trap_newpc", new_pc, 10'h3F0);
      tick();
      check_output("trap_pc", pc, 10'h3F0);
      run_instr("post_trap", 10'h3F0, 10'h3F1);

      tick(); tick();
      jump_req = 1'b1; jump_tgt = 10'h3FF;
      tick();
      jump_req = 1'b0;
      tick();
      check_output("to3ff_newpc", new_pc, 10'h3FF);
      tick();
      check_output("to3ff_pc", pc, 10'h3FF);

      // Stall three cycles in WB at 0x3FF, then the sequential wrap commits.
      tick(); tick(); tick(); tick();
      check_output("stall_wb", phase, 3'd5);
      stall = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         check_output("stall_we", pc_we, 1'b0);
         check_output("stall_phase", phase, 3'd5);
         tick();
      end
      check_output("stall_pc_held", pc, 10'h3FF);
      stall = 1'b0;
      #1;
      check_output("wrap_we", pc_we, 1'b1);
      check_output("wrap_newpc", new_pc, 10'h000);
      tick();
      check_output("wrap_pc", pc, 10'h000);
      check_output("wrap_fetch", phase, 3'd1);

      // Halt in WB commits then parks in IDLE.
      tick(); tick(); tick(); tick();
      halt = 1'b1;
      #1;
      check_output("halt_we", pc_we, 1'b1);
      check_output("halt_newpc", new_pc, 10'h001);
      tick();
      halt = 1'b0;
      check_output("halt_phase", phase, 3'd0);
      check_output("halt_busy", busy, 1'b0);
      check_output("halt_pc", pc, 10'h001);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_output("idle_phase", phase, 3'd0);
         check_output("idle_we", pc_we, 1'b0);
      end

      // Reset during MEM with a branch latched aborts the instruction.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      branch_req = 1'b1; branch_tgt = 10'h055;
      tick();
      branch_req = 1'b0;
      check_output("abort_mem", phase, 3'd4);
      rst_n = 1'b0;
      #1;
      check_output("abort_phase", phase, 3'd0);
      check_output("abort_pc", pc, 10'h000);
      check_output("abort_we", pc_we, 1'b0);
      check_output("abort_busy", busy, 1'b0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check_output("post_abort_phase", phase, 3'd0);
         check_output("post_abort_pc", pc, 10'h000);
         check_output("post_abort_we", pc_we, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
